// File: rtl/router_ctrl_fsm_pkg.sv
// ---------------------------------------------------------------------------
// router_pkg
// Shared types and constants for the 1x3 router control FSM.
//   state_e           : packet-sequencing states
//   ADDR_INVALID      : header address that never selects a FIFO
//   DEFAULT_NUM_PORTS : default number of destination FIFOs
//   addr_valid()      : header address is a real destination
// ---------------------------------------------------------------------------
package router_pkg;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_e;

  localparam logic [1:0] ADDR_INVALID      = 2'b11;
  localparam int         DEFAULT_NUM_PORTS = 3;

  // Address 3 is reserved; anything at or above the port count is also unusable.
  function automatic logic addr_valid(input logic [1:0] addr, input int num_ports);
    return (addr != ADDR_INVALID) && (int'({30'd0, addr}) < num_ports);
  endfunction

endpackage

// File: rtl/router_ctrl_fsm_if.sv
// ---------------------------------------------------------------------------
// router_ctrl_fsm_if
// Source-side handshake between the packet source and the router controller.
//   pkt_valid : source packet valid
//   data_in   : header address bits [1:0]
//   busy      : stall back to the source
// Modports: master = packet source, slave = router controller.
// ---------------------------------------------------------------------------
interface router_ctrl_fsm_if;

  logic       pkt_valid;
  logic [1:0] data_in;
  logic       busy;

  modport master (output pkt_valid, output data_in, input busy);
  modport slave  (input pkt_valid, input data_in, output busy);

endinterface

// File: rtl/router_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// router_ctrl_fsm
// Packet-sequencing controller for the 1x3 router. Decodes the header
// address, holds packet entry until the destination FIFO is empty, and
// drives the state strobes used by the router register block.
//
// Ports:
//   clock, reset      : clock and synchronous active-high reset
//   src (slave)       : pkt_valid / data_in in, busy out
//   fifo_full         : full flag of the selected FIFO
//   fifo_empty        : per-FIFO empty flags
//   soft_reset        : per-FIFO soft reset from the synchronizer
//   parity_done       : parity byte handled by the register block
//   low_packet_valid  : register block saw pkt_valid drop
//   dest_addr         : registered destination of the current packet
//   detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
//   write_enb_reg     : Moore decode of the current state
//   timeout           : one-cycle pulse after a WAIT_TILL_EMPTY timeout
//
// Optional feature ROUTER_FSM_WAIT_TIMEOUT_EN: bounds WAIT_TILL_EMPTY to
// WAIT_LIMIT cycles (the WAIT_LIMIT parameter exists only in that build).
// Without it the FSM waits indefinitely and timeout is tied low.
// ---------------------------------------------------------------------------
module router_ctrl_fsm
  import router_pkg::*;
#(
  parameter int NUM_PORTS = DEFAULT_NUM_PORTS
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
  , parameter int WAIT_LIMIT = 64
`endif
) (
  input  logic                 clock,
  input  logic                 reset,
  router_ctrl_fsm_if.slave     src,
  input  logic                 fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] soft_reset,
  input  logic                 parity_done,
  input  logic                 low_packet_valid,
  output logic [1:0]           dest_addr,
  output logic                 detect_add,
  output logic                 lfd_state,
  output logic                 ld_state,
  output logic                 laf_state,
  output logic                 full_state,
  output logic                 rst_int_reg,
  output logic                 write_enb_reg,
  output logic                 timeout
);

  state_e     state_r;
  state_e     next_s;
  logic [1:0] dest_addr_r;

  // Pad the per-port flags to the 4 values a 2-bit address can take so that
  // indexing by an address never leaves the vector.
  logic [3:0] empty_pad_s;
  logic [3:0] soft_pad_s;
  logic       hdr_ok_s;
  logic       hdr_empty_s;
  logic       sel_empty_s;
  logic       sel_soft_s;
  logic       wait_expired_s;

  assign empty_pad_s = 4'(fifo_empty);
  assign soft_pad_s  = 4'(soft_reset);
  assign hdr_ok_s    = addr_valid(src.data_in, NUM_PORTS);
  assign hdr_empty_s = empty_pad_s[src.data_in];
  assign sel_empty_s = empty_pad_s[dest_addr_r];
  assign sel_soft_s  = soft_pad_s[dest_addr_r];

`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
  localparam int CNT_W = $clog2(WAIT_LIMIT + 1);

  logic [CNT_W-1:0] wait_cnt_r;
  logic             timeout_r;

  // The count shows completed WAIT cycles, so the cycle holding WAIT_LIMIT-1
  // is the WAIT_LIMIT-th one and is the last cycle spent waiting.
  assign wait_expired_s = (state_r == WAIT_TILL_EMPTY) &&
                          (wait_cnt_r == CNT_W'(WAIT_LIMIT - 1));

  // Wait counter: cleared on entry to WAIT_TILL_EMPTY, counts cycles spent there.
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt_r <= '0;
    end else if ((state_r != WAIT_TILL_EMPTY) && (next_s == WAIT_TILL_EMPTY)) begin
      wait_cnt_r <= '0;
    end else if (state_r == WAIT_TILL_EMPTY) begin
      wait_cnt_r <= wait_cnt_r + CNT_W'(1);
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // Timeout pulse: high for the one cycle after a timed-out wait returns to decode.
  always_ff @(posedge clock) begin
    if (reset) begin
      timeout_r <= 1'b0;
    end else begin
      timeout_r <= wait_expired_s && !sel_empty_s && !sel_soft_s;
    end
  end

  assign timeout = timeout_r;
`else
  assign wait_expired_s = 1'b0;
  assign timeout        = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= DECODE_ADDRESS;
    end else begin
      state_r <= next_s;
    end
  end

  // Destination register: captured only from a valid header in DECODE_ADDRESS.
  always_ff @(posedge clock) begin
    if (reset) begin
      dest_addr_r <= 2'd0;
    end else if ((state_r == DECODE_ADDRESS) && src.pkt_valid && hdr_ok_s) begin
      dest_addr_r <= src.data_in;
    end else begin
      dest_addr_r <= dest_addr_r;
    end
  end

  assign dest_addr = dest_addr_r;

  // Next-state logic; a soft reset of the selected FIFO overrides every transition.
  always_comb begin
    next_s = state_r;
    if ((state_r != DECODE_ADDRESS) && sel_soft_s) begin
      next_s = DECODE_ADDRESS;
    end else begin
      case (state_r)
        DECODE_ADDRESS: begin
          if (src.pkt_valid && hdr_ok_s) begin
            next_s = hdr_empty_s ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
          end else begin
            next_s = DECODE_ADDRESS;
          end
        end
        WAIT_TILL_EMPTY: begin
          if (sel_empty_s) begin
            next_s = LOAD_FIRST_DATA;
          end else if (wait_expired_s) begin
            next_s = DECODE_ADDRESS;
          end else begin
            next_s = WAIT_TILL_EMPTY;
          end
        end
        LOAD_FIRST_DATA: next_s = LOAD_DATA;
        LOAD_DATA: begin
          if (fifo_full) begin
            next_s = FIFO_FULL_STATE;
          end else if (!src.pkt_valid) begin
            next_s = LOAD_PARITY;
          end else begin
            next_s = LOAD_DATA;
          end
        end
        FIFO_FULL_STATE: begin
          if (!fifo_full) begin
            next_s = LOAD_AFTER_FULL;
          end else begin
            next_s = FIFO_FULL_STATE;
          end
        end
        LOAD_AFTER_FULL: begin
          if (parity_done) begin
            next_s = DECODE_ADDRESS;
          end else if (low_packet_valid) begin
            next_s = LOAD_PARITY;
          end else begin
            next_s = LOAD_DATA;
          end
        end
        LOAD_PARITY: next_s = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: begin
          if (fifo_full) begin
            next_s = FIFO_FULL_STATE;
          end else begin
            next_s = DECODE_ADDRESS;
          end
        end
        default: next_s = DECODE_ADDRESS;
      endcase
    end
  end

  // Moore output decode of the current state.
  always_comb begin
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    rst_int_reg   = 1'b0;
    write_enb_reg = 1'b0;
    src.busy      = 1'b1;
    case (state_r)
      DECODE_ADDRESS: begin
        detect_add = 1'b1;
        src.busy   = 1'b0;
      end
      LOAD_FIRST_DATA: lfd_state = 1'b1;
      LOAD_DATA: begin
        ld_state      = 1'b1;
        write_enb_reg = 1'b1;
        src.busy      = 1'b0;
      end
      FIFO_FULL_STATE: full_state = 1'b1;
      LOAD_AFTER_FULL: begin
        laf_state     = 1'b1;
        write_enb_reg = 1'b1;
      end
      LOAD_PARITY:        write_enb_reg = 1'b1;
      CHECK_PARITY_ERROR: rst_int_reg   = 1'b1;
      WAIT_TILL_EMPTY:    src.busy      = 1'b1;
      default: begin
        detect_add = 1'b1;
        src.busy   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_router_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_router_ctrl_fsm
// Directed testbench for router_ctrl_fsm. The stimulus process pushes the
// expected outputs for each cycle into a queue; a monitor on the falling edge
// pops and compares them against the DUT.
// ---------------------------------------------------------------------------
module tb_router_ctrl_fsm;
  import router_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       fifo_full;
  logic [2:0] fifo_empty;
  logic [2:0] soft_reset;
  logic       parity_done;
  logic       low_packet_valid;
  logic [1:0] dest_addr;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
  logic       write_enb_reg, timeout;

  router_ctrl_fsm_if src_if ();

  router_ctrl_fsm #(
    .NUM_PORTS(3)
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
    , .WAIT_LIMIT(8)
`endif
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .src              (src_if.slave),
    .fifo_full        (fifo_full),
    .fifo_empty       (fifo_empty),
    .soft_reset       (soft_reset),
    .parity_done      (parity_done),
    .low_packet_valid (low_packet_valid),
    .dest_addr        (dest_addr),
    .detect_add       (detect_add),
    .lfd_state        (lfd_state),
    .ld_state         (ld_state),
    .laf_state        (laf_state),
    .full_state       (full_state),
    .rst_int_reg      (rst_int_reg),
    .write_enb_reg    (write_enb_reg),
    .timeout          (timeout)
  );

  always #5 clock = ~clock;

  // Expected entry: {dest_addr[1:0], outs[8:0]}.
  logic [10:0] exp_q[$];
  string       tag_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc_no = 0;

  // Hand-written output table, bit order:
  // {detect_add, lfd, ld, laf, full, rst_int_reg, write_enb_reg, busy, timeout}
  function automatic logic [8:0] exp_outs(input state_e s, input logic to);
    logic [8:0] v;
    case (s)
      DECODE_ADDRESS:     v = 9'b1000000_0_0;
      LOAD_FIRST_DATA:    v = 9'b0100000_1_0;
      LOAD_DATA:          v = 9'b0010001_0_0;
      LOAD_AFTER_FULL:    v = 9'b0001001_1_0;
      FIFO_FULL_STATE:    v = 9'b0000100_1_0;
      LOAD_PARITY:        v = 9'b0000001_1_0;
      CHECK_PARITY_ERROR: v = 9'b0000010_1_0;
      WAIT_TILL_EMPTY:    v = 9'b0000000_1_0;
      default:            v = 9'b0000000_0_0;
    endcase
    v[0] = to;
    return v;
  endfunction

  // Queue the expected outputs for the current cycle, then advance one clock.
  task automatic cyc(input string tag, input state_e s, input logic [1:0] da,
                     input logic to = 1'b0);
    exp_q.push_back({da, exp_outs(s, to)});
    tag_q.push_back($sformatf("%s#%0d", tag, cyc_no));
    cyc_no++;
    @(posedge clock);
    #1;
  endtask

  // Monitor: compare DUT outputs against the oldest expectation each cycle.
  always @(negedge clock) begin
    logic [10:0] e;
    logic [8:0]  got;
    string       t;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      t   = tag_q.pop_front();
      got = {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
             write_enb_reg, src_if.busy, timeout};
      checks++;
      if (got !== e[8:0]) begin
        errors++;
        $display("FAIL %s outs: got %b expected %b", t, got, e[8:0]);
      end
      checks++;
      if (dest_addr !== e[10:9]) begin
        errors++;
        $display("FAIL %s dest_addr: got %0d expected %0d", t, dest_addr, e[10:9]);
      end
    end
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; src_if.pkt_valid = 1'b0; src_if.data_in = 2'd0;
    fifo_full = 1'b0; fifo_empty = 3'b111; soft_reset = 3'b000;
    parity_done = 1'b0; low_packet_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    cyc("reset", DECODE_ADDRESS, 2'd0);
    reset = 1'b0;

    // Packet to port 1, all FIFOs empty.
    src_if.pkt_valid = 1'b1; src_if.data_in = 2'b01;
    cyc("p1_hdr", DECODE_ADDRESS, 2'd0);
    cyc("p1_lfd", LOAD_FIRST_DATA, 2'd1);
    cyc("p1_ld", LOAD_DATA, 2'd1);
    cyc("p1_ld", LOAD_DATA, 2'd1);
    src_if.pkt_valid = 1'b0;
    cyc("p1_ld", LOAD_DATA, 2'd1);
    cyc("p1_lp", LOAD_PARITY, 2'd1);
    cyc("p1_chk", CHECK_PARITY_ERROR, 2'd1);
    cyc("p1_idle", DECODE_ADDRESS, 2'd1);

    // Destination busy: wait until fifo_empty[1] rises.
    fifo_empty = 3'b101; src_if.pkt_valid = 1'b1; src_if.data_in = 2'b01;
    cyc("w_hdr", DECODE_ADDRESS, 2'd1);
    src_if.pkt_valid = 1'b0;
    cyc("w_wait", WAIT_TILL_EMPTY, 2'd1);
    fifo_empty = 3'b111;
    cyc("w_wait", WAIT_TILL_EMPTY, 2'd1);
    cyc("w_lfd", LOAD_FIRST_DATA, 2'd1);

    // FIFO full during load for 4 cycles, then recover.
    src_if.pkt_valid = 1'b1; fifo_full = 1'b1;
    cyc("f_ld", LOAD_DATA, 2'd1);
    cyc("f_full", FIFO_FULL_STATE, 2'd1);
    cyc("f_full", FIFO_FULL_STATE, 2'd1);
    cyc("f_full", FIFO_FULL_STATE, 2'd1);
    fifo_full = 1'b0;
    cyc("f_full", FIFO_FULL_STATE, 2'd1);
    cyc("f_laf", LOAD_AFTER_FULL, 2'd1);
    src_if.pkt_valid = 1'b0;
    cyc("f_ld2", LOAD_DATA, 2'd1);
    cyc("f_lp", LOAD_PARITY, 2'd1);
    fifo_full = 1'b1;
    cyc("f_chk", CHECK_PARITY_ERROR, 2'd1);
    fifo_full = 1'b0;
    cyc("f_full2", FIFO_FULL_STATE, 2'd1);
    parity_done = 1'b1;
    cyc("f_laf2", LOAD_AFTER_FULL, 2'd1);
    parity_done = 1'b0;
    cyc("f_idle", DECODE_ADDRESS, 2'd1);

    // Invalid header address 3 held for 5 cycles.
    src_if.pkt_valid = 1'b1; src_if.data_in = 2'b11;
    for (int i = 0; i < 5; i++) cyc("inv", DECODE_ADDRESS, 2'd1);
    src_if.pkt_valid = 1'b0; src_if.data_in = 2'b00;
    cyc("inv_idle", DECODE_ADDRESS, 2'd1);

    // Soft reset: non-selected port ignored, selected port aborts.
    src_if.pkt_valid = 1'b1; src_if.data_in = 2'b10;
    cyc("s_hdr", DECODE_ADDRESS, 2'd1);
    cyc("s_lfd", LOAD_FIRST_DATA, 2'd2);
    soft_reset = 3'b001;
    cyc("s_other", LOAD_DATA, 2'd2);
    soft_reset = 3'b100;
    cyc("s_sel", LOAD_DATA, 2'd2);
    soft_reset = 3'b000; src_if.pkt_valid = 1'b0;
    cyc("s_idle", DECODE_ADDRESS, 2'd2);

    // low_packet_valid branch, then synchronous reset mid-LAF.
    src_if.pkt_valid = 1'b1; src_if.data_in = 2'b10;
    cyc("r_hdr", DECODE_ADDRESS, 2'd2);
    cyc("r_lfd", LOAD_FIRST_DATA, 2'd2);
    fifo_full = 1'b1;
    cyc("r_ld", LOAD_DATA, 2'd2);
    fifo_full = 1'b0;
    cyc("r_full", FIFO_FULL_STATE, 2'd2);
    low_packet_valid = 1'b1;
    cyc("r_laf_lpv", LOAD_AFTER_FULL, 2'd2);
    low_packet_valid = 1'b0; src_if.pkt_valid = 1'b0;
    cyc("r_lp", LOAD_PARITY, 2'd2);
    fifo_full = 1'b1;
    cyc("r_chk", CHECK_PARITY_ERROR, 2'd2);
    fifo_full = 1'b0;
    cyc("r_full2", FIFO_FULL_STATE, 2'd2);
    reset = 1'b1;
    cyc("r_laf_rst", LOAD_AFTER_FULL, 2'd2);
    reset = 1'b0;
    cyc("r_after", DECODE_ADDRESS, 2'd0);

`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
    // Target FIFO never empties: give up after 8 WAIT cycles.
    fifo_empty = 3'b110; src_if.pkt_valid = 1'b1; src_if.data_in = 2'b00;
    cyc("t_hdr", DECODE_ADDRESS, 2'd0);
    src_if.pkt_valid = 1'b0;
    for (int i = 0; i < 8; i++) cyc("t_wait", WAIT_TILL_EMPTY, 2'd0);
    cyc("t_pulse", DECODE_ADDRESS, 2'd0, 1'b1);
    cyc("t_after", DECODE_ADDRESS, 2'd0);
    fifo_empty = 3'b111;
`endif

    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_ctrl_fsm.md
Name: router_ctrl_fsm

Overview:
- Packet-sequencing controller for the 1x3 router.
- Decodes the header address, gates packet entry on destination FIFO availability, and drives the state strobes consumed by the router register block.
- Those strobes are detect_add, lfd_state, ld_state, laf_state, full_state and rst_int_reg.
- Sits between the input interface, the three output FIFOs/synchronizer and the router register block; drives busy back to the source.

Parameters:
- NUM_PORTS, 3, number of destination FIFOs; valid addresses are 0..NUM_PORTS-1, and address 3 is invalid.
- WAIT_LIMIT, 64, cycle limit for WAIT_TILL_EMPTY; used only when the optional feature is enabled.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pkt_valid  in  1  source packet valid
- data_in  in  2  header address bits data_in[1:0]
- fifo_full  in  1  full flag of the currently selected FIFO
- fifo_empty  in  NUM_PORTS  per-FIFO empty flags
- soft_reset  in  NUM_PORTS  per-FIFO soft reset from synchronizer
- parity_done  in  1  from router register block
- low_packet_valid  in  1  from router register block
- dest_addr  out  2  registered destination of the current packet
- detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg  out  1 each  state strobes
- write_enb_reg  out  1  FIFO write enable
- busy  out  1  stall to source
- timeout  out  1  wait-timeout pulse (optional feature; tied 0 when disabled)

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset forces state=DECODE_ADDRESS and dest_addr=0. All strobes then follow the state decode: detect_add=1, all other strobes 0, busy=0, timeout=0.
- Outputs are a combinational Moore decode of the registered state, with no output latency:
  - detect_add = DECODE_ADDRESS
  - lfd_state = LOAD_FIRST_DATA
  - ld_state = LOAD_DATA
  - full_state = FIFO_FULL_STATE
  - laf_state = LOAD_AFTER_FULL
  - rst_int_reg = CHECK_PARITY_ERROR
  - write_enb_reg = LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL
  - busy = every state except DECODE_ADDRESS and LOAD_DATA
- dest_addr loads data_in when state==DECODE_ADDRESS and pkt_valid=1 and data_in!=3. It holds otherwise.
- Transitions:
  - DECODE_ADDRESS:
    - pkt_valid and addr<3 and fifo_empty[addr] -> LOAD_FIRST_DATA.
    - pkt_valid and addr<3 and !fifo_empty[addr] -> WAIT_TILL_EMPTY.
    - addr==3 or !pkt_valid -> stay.
  - WAIT_TILL_EMPTY: fifo_empty[dest_addr] -> LOAD_FIRST_DATA; else stay.
  - LOAD_FIRST_DATA -> LOAD_DATA, unconditionally.
  - LOAD_DATA: fifo_full -> FIFO_FULL_STATE; else !pkt_valid -> LOAD_PARITY; else stay. fifo_full takes priority.
  - FIFO_FULL_STATE: !fifo_full -> LOAD_AFTER_FULL; else stay.
  - LOAD_AFTER_FULL:
    - parity_done -> DECODE_ADDRESS.
    - else low_packet_valid -> LOAD_PARITY.
    - else -> LOAD_DATA.
  - LOAD_PARITY -> CHECK_PARITY_ERROR.
  - CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
- soft_reset[dest_addr]=1 in any state other than DECODE_ADDRESS forces DECODE_ADDRESS next cycle; dest_addr is held.
- soft_reset on a non-selected port is ignored.
- Priority: reset > soft_reset[dest_addr] > normal transitions.
- Reset mid-packet: return to DECODE_ADDRESS next cycle; no strobe other than detect_add is asserted.
- Unreachable state encodings recover to DECODE_ADDRESS.

Optional Feature:
- Macro: ROUTER_FSM_WAIT_TIMEOUT_EN.
- Enabled:
  - A counter of width clog2(WAIT_LIMIT+1) clears on entry to WAIT_TILL_EMPTY and increments each cycle spent there.
  - When the count reaches WAIT_LIMIT with fifo_empty[dest_addr] still 0, the FSM goes to DECODE_ADDRESS and timeout pulses high for 1 cycle.
  - The counter clears on reset.
- Disabled: no counter; WAIT_TILL_EMPTY waits indefinitely; timeout is tied 0.

Decomposition:
- Package router_pkg holds:
  - state enum: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY
  - ADDR_INVALID=2'b11
  - NUM_PORTS default
- Single module; no sub-module. The timeout counter is inline under the macro.

Test Plan:
- Packet to port 1 with all FIFOs empty: header 0x05, 3 payload bytes, then pkt_valid drops.
  - Required state sequence: DECODE -> LFD -> LD x3 -> LOAD_PARITY -> CHECK -> DECODE.
  - dest_addr=1; busy high only in the LFD, LOAD_PARITY and CHECK cycles.
- fifo_empty=3'b101 and header addr=1 -> WAIT_TILL_EMPTY with busy=1.
  - Raise fifo_empty[1] -> LFD next cycle.
- fifo_full asserted during LD for 4 cycles -> FULL_STATE held 4 cycles, full_state=1, write_enb_reg=0.
  - Release fifo_full -> LAF; with parity_done=0 and low_packet_valid=0 -> LD.
- Header addr=3 with pkt_valid=1 for 5 cycles -> stays in DECODE, dest_addr unchanged, busy=0.
- soft_reset[2]=1 while in LD with dest_addr=2 -> DECODE next cycle.
  - soft_reset[0] in the same situation has no effect.
- With ROUTER_FSM_WAIT_TIMEOUT_EN and WAIT_LIMIT=8, target FIFO never empty -> DECODE after 8 WAIT cycles, with a single-cycle timeout pulse.
  - Synchronous reset asserted mid-LAF -> DECODE on the next clock.
